icache_nway: RTL

ICACHE_NWAY -- requirements
Module: icache_nway

---
 rtl/icache_nway.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative instruction cache with true-LRU replacement
//
// Ports:
//   clk, rst                      rising-edge clock, asynchronous active-low reset
//   req_valid/req_addr/req_ready  fetch request; accepted when req_valid && req_ready
//   rsp_valid/rsp_data/rsp_ready  32-bit instruction response, held until rsp_ready
//   flush                         fence.i: invalidate every line
//   mem_req_valid/addr/ready      line-aligned refill request
//   mem_rsp_valid/mem_rsp_data    refill beats, ascending address order
module icache_nway #(
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_BEATS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        rsp_ready,
    input  logic        flush,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [63:0] mem_rsp_data
);
    localparam int OFF = 3 + $clog2(LINE_BEATS);
    localparam int IW  = $clog2(SETS);
    localparam int TW  = 64 - OFF - IW;
    localparam int AW  = $clog2(WAYS);
    localparam int BW  = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        RESP,
        FLUSH
    } state_t;

    state_t state_q, state_d;

    // Byte-lane bits of the fetch address carry no information for 32-bit fetches.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr[1:0];

    logic [63:2]   addr_q;
    logic [AW-1:0] way_q;          // hit way after LOOKUP, victim way on a miss
    logic [BW-1:0] beat_q;
    logic          flush_pend_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_data_q;

    logic [WAYS-1:0] valid_q  [SETS];
    logic [AW-1:0]   age_q    [SETS][WAYS];
    logic [TW-1:0]   tag_mem  [SETS][WAYS];
    logic [63:0]     data_mem [SETS][WAYS][LINE_BEATS];

    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic [BW-1:0] rd_beat;
    logic [63:0]   rd_line;
    logic [31:0]   rd_word;

    assign idx     = addr_q[OFF +: IW];
    assign tag     = addr_q[63 -: TW];
    assign rd_beat = (LINE_BEATS > 1) ? addr_q[3 +: BW] : '0;
    assign rd_line = data_mem[idx][way_q][rd_beat];
    assign rd_word = addr_q[2] ? rd_line[63:32] : rd_line[31:0];

    // Tag match and victim choice for the indexed set.
    logic          hit;
    logic [AW-1:0] hit_way;
    logic [AW-1:0] victim;
    logic          found_free;

    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        victim     = '0;
        found_free = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[idx][w] && (tag_mem[idx][w] == tag)) begin
                hit     = 1'b1;
                hit_way = AW'(w);
            end
            if (!valid_q[idx][w] && !found_free) begin
                victim     = AW'(w);
                found_free = 1'b1;
            end
        end
        // Ages in a set are a permutation of 0..WAYS-1, so exactly one way is oldest.
        if (!found_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (age_q[idx][w] == AW'(WAYS - 1)) begin
                    victim = AW'(w);
                end
            end
        end
    end

    logic          last_beat;
    logic          fill_done;
    logic          lru_upd;
    logic [AW-1:0] acc_way;

    assign last_beat = (beat_q == BW'(LINE_BEATS - 1));
    assign fill_done = (state_q == REFILL) && mem_rsp_valid && last_beat;
    assign lru_upd   = ((state_q == LOOKUP) && hit) || fill_done;
    assign acc_way   = (state_q == LOOKUP) ? hit_way : way_q;

    assign req_ready     = rst && (state_q == IDLE) && !flush && !flush_pend_q;
    assign mem_req_valid = (state_q == MISS_REQ);
    assign mem_req_addr  = mem_req_valid ? {addr_q[63:OFF], {OFF{1'b0}}} : '0;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (req_valid && req_ready) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP:   state_d = hit ? RESP : MISS_REQ;
            MISS_REQ: if (mem_req_ready) state_d = REFILL;
            REFILL:   if (fill_done) state_d = RESP;
            RESP: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = (flush_pend_q || flush) ? FLUSH : IDLE;
                end
            end
            FLUSH:    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Control registers. The response word is captured on the first RESP
    // cycle from the array, giving the two-cycle hit latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q       <= '0;
            way_q        <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= '0;
        end else begin
            if (req_valid && req_ready) begin
                addr_q <= req_addr[63:2];
            end
            if (state_q == LOOKUP) begin
                way_q <= hit ? hit_way : victim;
            end
            if (state_q == MISS_REQ) begin
                beat_q <= '0;
            end else if ((state_q == REFILL) && mem_rsp_valid) begin
                beat_q <= beat_q + 1'b1;
            end
            if (state_q == FLUSH) begin
                flush_pend_q <= 1'b0;
            end else if (flush && (state_q != IDLE)) begin
                flush_pend_q <= 1'b1;
            end
            if (state_q == RESP) begin
                if (!rsp_valid_q) begin
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= rd_word;
                end else if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                end
            end
        end
    end

    // Valid bits and LRU ages. A line only becomes valid on its last beat,
    // so a reset or abort mid-refill never exposes a partial line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
        end else if (state_q == FLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= AW'(w);
                end
            end
        end else begin
            if (fill_done) begin
                valid_q[idx][way_q] <= 1'b1;
            end
            if (lru_upd) begin
                for (int v = 0; v < WAYS; v++) begin
                    if (age_q[idx][v] < age_q[idx][acc_way]) begin
                        age_q[idx][v] <= age_q[idx][v] + 1'b1;
                    end
                end
                age_q[idx][acc_way] <= '0;
            end
        end
    end

    // Tag and data arrays need no reset: they are qualified by valid_q.
    always_ff @(posedge clk) begin
        if ((state_q == REFILL) && mem_rsp_valid) begin
            data_mem[idx][way_q][beat_q] <= mem_rsp_data;
        end
        if (fill_done) begin
            tag_mem[idx][way_q] <= tag;
        end
    end

endmodule
